// File: rtl/i2c_bus_monitor.sv
// rtl/i2c_bus_monitor.sv - I2C line monitor: sync/deglitch, START/RSTART/STOP, byte framing, timeout
// Lines are indexed 0 = SCL, 1 = SDA in the synchroniser/filter arrays.
module i2c_bus_monitor #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3,
   parameter int TIMEOUT_W   = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 scl_in,
   input  logic                 sda_in,
   input  logic [TIMEOUT_W-1:0] timeout_limit,
   output logic                 scl_f,
   output logic                 sda_f,
   output logic                 scl_rise,
   output logic                 scl_fall,
   output logic                 start_pulse,
   output logic                 rstart_pulse,
   output logic                 stop_pulse,
   output logic                 bus_busy,
   output logic                 byte_valid,
   output logic [7:0]           byte_data,
   output logic                 ack_valid,
   output logic                 ack_bit,
   output logic                 timeout_pulse
);

   localparam int               CNT_W   = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_LEN - 1);

   typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

   logic [SYNC_STAGES-1:0] r_sync [2];
   logic [CNT_W-1:0]       r_fcnt [2];
   logic [1:0]             r_filt;
   logic [1:0]             r_prev;
   logic [1:0]             w_raw;

   state_t                 r_state;
   state_t                 w_state_next;
   logic                   w_active;
   logic [TIMEOUT_W-1:0]   r_to_cnt;

   logic w_scl_rise, w_scl_fall, w_sda_rise, w_sda_fall, w_scl_high, w_any_edge;
   logic w_start, w_rstart, w_stop, w_timeout;

   logic [3:0] r_bit_cnt;
   logic [6:0] r_shift;
   logic [7:0] r_byte_data;
   logic       r_byte_valid, r_ack_valid, r_ack_bit;
   logic       r_scl_rise, r_scl_fall, r_start, r_rstart, r_stop, r_timeout;

   assign w_raw = {sda_in, scl_in};

   // Filtered level only follows after the sync output has disagreed for FILTER_LEN cycles.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            r_sync[i] <= '1;
            r_fcnt[i] <= '0;
            r_filt[i] <= 1'b1;
         end else begin
            r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], w_raw[i]};
            if (r_sync[i][SYNC_STAGES-1] == r_filt[i]) begin
               r_fcnt[i] <= '0;
            end else if (r_fcnt[i] == CNT_MAX) begin
               r_filt[i] <= r_sync[i][SYNC_STAGES-1];
               r_fcnt[i] <= '0;
            end else begin
               r_fcnt[i] <= r_fcnt[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) r_prev <= 2'b11;
      else       r_prev <= r_filt;
   end

   assign w_scl_rise = r_filt[0] & ~r_prev[0];
   assign w_scl_fall = ~r_filt[0] & r_prev[0];
   assign w_sda_rise = r_filt[1] & ~r_prev[1];
   assign w_sda_fall = ~r_filt[1] & r_prev[1];
   assign w_scl_high = r_filt[0] & r_prev[0];
   assign w_any_edge = |(r_filt ^ r_prev);
   assign w_active   = (r_state == ST_ACTIVE);

   // A condition needs SCL steady high, so any cycle with an SDA condition has an edge
   // and can never coincide with a timeout.
   always_comb begin
      w_state_next = r_state;
      w_start      = 1'b0;
      w_rstart     = 1'b0;
      w_stop       = 1'b0;
      w_timeout    = 1'b0;
      if (w_sda_rise && w_scl_high) begin
         w_stop       = 1'b1;
         w_state_next = ST_IDLE;
      end else if (w_sda_fall && w_scl_high) begin
         w_start      = !w_active;
         w_rstart     = w_active;
         w_state_next = ST_ACTIVE;
      end else if (w_active && (timeout_limit != '0) && !w_any_edge &&
                   (r_to_cnt >= timeout_limit - 1'b1)) begin
         w_timeout    = 1'b1;
         w_state_next = ST_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_next;
   end

   always_ff @(posedge clk) begin
      if (reset || !w_active || w_any_edge) r_to_cnt <= '0;
      else if (r_to_cnt != '1)              r_to_cnt <= r_to_cnt + 1'b1;
   end

   // Bit framing: 8 data bits then the ACK bit on the 9th SCL rise.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_byte_data  <= '0;
         r_byte_valid <= 1'b0;
         r_ack_valid  <= 1'b0;
         r_ack_bit    <= 1'b0;
      end else begin
         r_byte_valid <= 1'b0;
         r_ack_valid  <= 1'b0;
         if (w_start || w_rstart || w_stop || w_timeout || !w_active) begin
            r_bit_cnt <= '0;
         end else if (w_scl_rise) begin
            r_shift <= {r_shift[5:0], r_filt[1]};
            if (r_bit_cnt == 4'd7) begin
               r_byte_data  <= {r_shift, r_filt[1]};
               r_byte_valid <= 1'b1;
               r_bit_cnt    <= 4'd8;
            end else if (r_bit_cnt == 4'd8) begin
               r_ack_bit   <= r_filt[1];
               r_ack_valid <= 1'b1;
               r_bit_cnt   <= '0;
            end else begin
               r_bit_cnt <= r_bit_cnt + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_scl_rise <= 1'b0;
         r_scl_fall <= 1'b0;
         r_start    <= 1'b0;
         r_rstart   <= 1'b0;
         r_stop     <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         r_scl_rise <= w_scl_rise;
         r_scl_fall <= w_scl_fall;
         r_start    <= w_start;
         r_rstart   <= w_rstart;
         r_stop     <= w_stop;
         r_timeout  <= w_timeout;
      end
   end

   assign scl_f         = r_filt[0];
   assign sda_f         = r_filt[1];
   assign scl_rise      = r_scl_rise;
   assign scl_fall      = r_scl_fall;
   assign start_pulse   = r_start;
   assign rstart_pulse  = r_rstart;
   assign stop_pulse    = r_stop;
   assign bus_busy      = w_active;
   assign byte_valid    = r_byte_valid;
   assign byte_data     = r_byte_data;
   assign ack_valid     = r_ack_valid;
   assign ack_bit       = r_ack_bit;
   assign timeout_pulse = r_timeout;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// tb/tb_i2c_bus_monitor.sv - directed self-checking bench for i2c_bus_monitor
`timescale 1ns/1ps
module tb_i2c_bus_monitor;

   logic        clk = 1'b0;
   logic        reset;
   logic        scl_in;
   logic        sda_in;
   logic [15:0] timeout_limit;
   logic        scl_f, sda_f, scl_rise, scl_fall;
   logic        start_pulse, rstart_pulse, stop_pulse, bus_busy;
   logic        byte_valid, ack_valid, ack_bit, timeout_pulse;
   logic [7:0]  byte_data;

   int checks = 0;
   int errors = 0;

   int n_start = 0, n_rstart = 0, n_stop = 0, n_bv = 0, n_av = 0;
   int n_to = 0, n_rise = 0, n_sda_low = 0;
   logic [7:0] mon_byte = 8'h00;
   logic       mon_ack  = 1'b0;

   int b_start, b_rstart, b_stop, b_bv, b_av, b_to, b_rise, b_sda_low;

   always #5 clk = ~clk;

   i2c_bus_monitor dut (
      .clk           (clk),
      .reset         (reset),
      .scl_in        (scl_in),
      .sda_in        (sda_in),
      .timeout_limit (timeout_limit),
      .scl_f         (scl_f),
      .sda_f         (sda_f),
      .scl_rise      (scl_rise),
      .scl_fall      (scl_fall),
      .start_pulse   (start_pulse),
      .rstart_pulse  (rstart_pulse),
      .stop_pulse    (stop_pulse),
      .bus_busy      (bus_busy),
      .byte_valid    (byte_valid),
      .byte_data     (byte_data),
      .ack_valid     (ack_valid),
      .ack_bit       (ack_bit),
      .timeout_pulse (timeout_pulse)
   );

   // Pulses are one clock wide and stable between posedges, so one negedge sample counts each once.
   always @(negedge clk) begin
      if (start_pulse)   n_start++;
      if (rstart_pulse)  n_rstart++;
      if (stop_pulse)    n_stop++;
      if (timeout_pulse) n_to++;
      if (scl_rise)      n_rise++;
      if (!sda_f)        n_sda_low++;
      if (byte_valid) begin n_bv++; mon_byte = byte_data; end
      if (ack_valid)  begin n_av++; mon_ack  = ack_bit;   end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic snap();
      b_start = n_start; b_rstart = n_rstart; b_stop = n_stop; b_bv = n_bv;
      b_av = n_av; b_to = n_to; b_rise = n_rise; b_sda_low = n_sda_low;
   endtask

   task automatic send_bit(input logic b);
      sda_in = b;
      cyc(20);
      scl_in = 1'b1;
      cyc(20);
      scl_in = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) send_bit(v[i]);
   endtask

   task automatic do_start();
      sda_in = 1'b0;
      cyc(20);
      scl_in = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; scl_in = 1'b1; sda_in = 1'b1; timeout_limit = 16'd0;
      cyc(5);
      @(posedge clk); #1;
      checks++; if ({scl_f, sda_f} !== 2'b11) begin errors++; $display("FAIL reset_levels: got %b expected 11", {scl_f, sda_f}); end
      checks++; if ({start_pulse, rstart_pulse, stop_pulse, scl_rise, scl_fall, byte_valid, ack_valid, timeout_pulse, bus_busy, ack_bit} !== 10'd0) begin
         errors++; $display("FAIL reset_flags: got %b expected 0", {start_pulse, rstart_pulse, stop_pulse, scl_rise, scl_fall, byte_valid, ack_valid, timeout_pulse, bus_busy, ack_bit}); end
      checks++; if (byte_data !== 8'h00) begin errors++; $display("FAIL reset_byte_data: got %h expected 00", byte_data); end
      @(negedge clk);
      reset = 1'b0;
      cyc(12);
   endtask

   task automatic test_start();
      snap();
      sda_in = 1'b0;
      repeat (5) @(posedge clk); #1;
      checks++; if (start_pulse !== 1'b0) begin errors++; $display("FAIL start_early: got %b expected 0", start_pulse); end
      @(posedge clk); #1;
      checks++; if (start_pulse !== 1'b1) begin errors++; $display("FAIL start_at_6: got %b expected 1", start_pulse); end
      checks++; if (bus_busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b expected 1", bus_busy); end
      @(posedge clk); #1;
      checks++; if (start_pulse !== 1'b0) begin errors++; $display("FAIL start_width: got %b expected 0", start_pulse); end
      cyc(13);
      scl_in = 1'b0;
      cyc(10);
      checks++; if (n_start - b_start !== 1) begin errors++; $display("FAIL start_count: got %0d expected 1", n_start - b_start); end
      checks++; if ((n_rstart - b_rstart) + (n_stop - b_stop) !== 0) begin errors++; $display("FAIL start_other_conds: got %0d expected 0", (n_rstart - b_rstart) + (n_stop - b_stop)); end
   endtask

   task automatic test_byte();
      snap();
      send_byte(8'hA5);
      send_bit(1'b0);
      cyc(10);
      checks++; if (n_bv - b_bv !== 1) begin errors++; $display("FAIL byte_a5_count: got %0d expected 1", n_bv - b_bv); end
      checks++; if (mon_byte !== 8'hA5) begin errors++; $display("FAIL byte_a5_data: got %h expected a5", mon_byte); end
      checks++; if (n_av - b_av !== 1) begin errors++; $display("FAIL ack_count: got %0d expected 1", n_av - b_av); end
      checks++; if (mon_ack !== 1'b0) begin errors++; $display("FAIL ack_bit: got %b expected 0", mon_ack); end
      checks++; if (n_rise - b_rise !== 9) begin errors++; $display("FAIL scl_rise_count: got %0d expected 9", n_rise - b_rise); end
      checks++; if (byte_data !== 8'hA5) begin errors++; $display("FAIL byte_data_hold: got %h expected a5", byte_data); end
   endtask

   task automatic test_rstart();
      snap();
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      sda_in = 1'b1;
      cyc(20);
      scl_in = 1'b1;
      cyc(20);
      sda_in = 1'b0;
      cyc(20);
      scl_in = 1'b0;
      checks++; if (n_rstart - b_rstart !== 1) begin errors++; $display("FAIL rstart_count: got %0d expected 1", n_rstart - b_rstart); end
      checks++; if (n_start - b_start !== 0) begin errors++; $display("FAIL rstart_no_start: got %0d expected 0", n_start - b_start); end
      checks++; if (n_bv - b_bv !== 0) begin errors++; $display("FAIL rstart_partial_byte: got %0d expected 0", n_bv - b_bv); end
      send_byte(8'h3C);
      send_bit(1'b1);
      cyc(10);
      checks++; if (n_bv - b_bv !== 1) begin errors++; $display("FAIL byte_3c_count: got %0d expected 1", n_bv - b_bv); end
      checks++; if (mon_byte !== 8'h3C) begin errors++; $display("FAIL byte_3c_data: got %h expected 3c", mon_byte); end
      checks++; if (mon_ack !== 1'b1) begin errors++; $display("FAIL nack_bit: got %b expected 1", mon_ack); end
      checks++; if (bus_busy !== 1'b1) begin errors++; $display("FAIL rstart_busy: got %b expected 1", bus_busy); end
   endtask

   task automatic test_stop();
      snap();
      sda_in = 1'b0;
      cyc(20);
      scl_in = 1'b1;
      cyc(20);
      sda_in = 1'b1;
      repeat (5) @(posedge clk); #1;
      checks++; if ({stop_pulse, bus_busy} !== 2'b01) begin errors++; $display("FAIL stop_early: got %b expected 01", {stop_pulse, bus_busy}); end
      @(posedge clk); #1;
      checks++; if ({stop_pulse, bus_busy} !== 2'b10) begin errors++; $display("FAIL stop_at_6: got %b expected 10", {stop_pulse, bus_busy}); end
      cyc(20);
      checks++; if (n_stop - b_stop !== 1) begin errors++; $display("FAIL stop_count: got %0d expected 1", n_stop - b_stop); end
   endtask

   task automatic test_glitch();
      snap();
      sda_in = 1'b0;
      cyc(2);
      sda_in = 1'b1;
      cyc(20);
      checks++; if (n_sda_low - b_sda_low !== 0) begin errors++; $display("FAIL glitch_sda_f: got %0d low cycles expected 0", n_sda_low - b_sda_low); end
      checks++; if ((n_start - b_start) + (n_rstart - b_rstart) + (n_stop - b_stop) !== 0) begin
         errors++; $display("FAIL glitch_conds: got %0d expected 0", (n_start - b_start) + (n_rstart - b_rstart) + (n_stop - b_stop)); end
   endtask

   task automatic test_timeout();
      timeout_limit = 16'd100;
      snap();
      sda_in = 1'b0;
      repeat (6) @(posedge clk); #1;
      checks++; if (start_pulse !== 1'b1) begin errors++; $display("FAIL to_start: got %b expected 1", start_pulse); end
      repeat (99) @(posedge clk); #1;
      checks++; if ({timeout_pulse, bus_busy} !== 2'b01) begin errors++; $display("FAIL to_early: got %b expected 01", {timeout_pulse, bus_busy}); end
      @(posedge clk); #1;
      checks++; if ({timeout_pulse, bus_busy} !== 2'b10) begin errors++; $display("FAIL to_fire: got %b expected 10", {timeout_pulse, bus_busy}); end
      cyc(5);
      sda_in = 1'b1;
      cyc(20);
      checks++; if (n_stop - b_stop !== 1) begin errors++; $display("FAIL idle_stop_count: got %0d expected 1", n_stop - b_stop); end
      checks++; if ({n_to - b_to, 31'd0, bus_busy} !== {32'd1, 31'd0, 1'b0}) begin errors++; $display("FAIL to_count_busy: got %0d/%b expected 1/0", n_to - b_to, bus_busy); end
   endtask

   task automatic test_no_timeout();
      timeout_limit = 16'd0;
      snap();
      sda_in = 1'b0;
      cyc(300);
      checks++; if (n_to - b_to !== 0) begin errors++; $display("FAIL no_to_count: got %0d expected 0", n_to - b_to); end
      checks++; if (bus_busy !== 1'b1) begin errors++; $display("FAIL no_to_busy: got %b expected 1", bus_busy); end
      sda_in = 1'b1;
      cyc(20);
      checks++; if (bus_busy !== 1'b0) begin errors++; $display("FAIL no_to_stop_busy: got %b expected 0", bus_busy); end
   endtask

   task automatic test_reset_midbyte();
      do_start();
      send_bit(1'b1); send_bit(1'b0);
      sda_in = 1'b1;
      cyc(20);
      scl_in = 1'b1;
      cyc(10);
      reset = 1'b1;
      @(posedge clk); #1;
      checks++; if ({bus_busy, ack_bit, byte_data} !== 10'd0) begin errors++; $display("FAIL midreset_state: got %b expected 0", {bus_busy, ack_bit, byte_data}); end
      checks++; if ({start_pulse, rstart_pulse, stop_pulse, scl_rise, scl_fall, byte_valid, ack_valid, timeout_pulse} !== 8'd0) begin
         errors++; $display("FAIL midreset_pulses: got %b expected 0", {start_pulse, rstart_pulse, stop_pulse, scl_rise, scl_fall, byte_valid, ack_valid, timeout_pulse}); end
      checks++; if ({scl_f, sda_f} !== 2'b11) begin errors++; $display("FAIL midreset_levels: got %b expected 11", {scl_f, sda_f}); end
      @(negedge clk);
      reset = 1'b0;
      cyc(20);
      snap();
      do_start();
      send_byte(8'h5A);
      send_bit(1'b0);
      cyc(10);
      checks++; if (n_start - b_start !== 1) begin errors++; $display("FAIL post_reset_start: got %0d expected 1", n_start - b_start); end
      checks++; if (n_bv - b_bv !== 1) begin errors++; $display("FAIL post_reset_byte_count: got %0d expected 1", n_bv - b_bv); end
      checks++; if (mon_byte !== 8'h5A) begin errors++; $display("FAIL post_reset_byte: got %h expected 5a", mon_byte); end
      checks++; if ({n_av - b_av, 31'd0, mon_ack} !== {32'd1, 31'd0, 1'b0}) begin errors++; $display("FAIL post_reset_ack: got %0d/%b expected 1/0", n_av - b_av, mon_ack); end
      sda_in = 1'b0;
      cyc(20);
      scl_in = 1'b1;
      cyc(20);
      sda_in = 1'b1;
      cyc(20);
      checks++; if (bus_busy !== 1'b0) begin errors++; $display("FAIL final_stop_busy: got %b expected 0", bus_busy); end
   endtask

   initial begin
      test_reset();
      test_start();
      test_byte();
      test_rstart();
      test_stop();
      test_glitch();
      test_timeout();
      test_no_timeout();
      test_reset_midbyte();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
